v6_peak_detector: RTL and testbench

- Downstream consumer of the v6 shaping filter output; one signed shaped sample per clock.
- Detects threshold-crossing pulses, tracks the running maximum, and emits one amplitude/timestamp record per accepted pulse with a single-cycle valid strobe.
- Rejects runts, flags pile-up/overlong pulses, and enforces a dead time before re-arming.
- Feeds the event readout stage.

---
 rtl/v6_peak_detector.sv | 144 ++++++++++++++
 tb/tb_v6_peak_detector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/v6_peak_detector.sv
// Peak detector for shaped filter samples: threshold/hysteresis pulse capture,
// running maximum with timestamp, runt rejection, pile-up flag and dead time.
//
// state | meaning
// IDLE  | waiting for x > THRESHOLD
// ARMED | pulse in progress, tracking maximum and width
// DEAD  | record emitted, holding off re-arm until timer expires and x <= THRESHOLD
module v6_peak_detector #(
    parameter int SIZE_FILTER_DATA = 15,
    parameter int THRESHOLD        = 100,
    parameter int HYST             = 10,
    parameter int MIN_WIDTH        = 3,
    parameter int MAX_WIDTH        = 64,
    parameter int DEADTIME         = 8,
    parameter int TS_WIDTH         = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [SIZE_FILTER_DATA:0] filter_data,
    output logic signed [SIZE_FILTER_DATA:0] peak_amplitude,
    output logic [TS_WIDTH-1:0]           peak_time,
    output logic                          peak_valid,
    output logic                          pile_up,
    output logic                          busy,
    output logic [15:0]                   event_count,
    output logic [15:0]                   runt_count
);
    localparam int DW = SIZE_FILTER_DATA + 1;
    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int CW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

    // One extra bit so THRESHOLD-HYST cannot wrap at the sample width.
    localparam logic signed [DW:0] THR_EXT   = (DW + 1)'(THRESHOLD);
    localparam logic signed [DW:0] LOW_EXT   = (DW + 1)'(THRESHOLD - HYST);
    localparam logic [WW-1:0]      MIN_W     = WW'(MIN_WIDTH);
    localparam logic [WW-1:0]      MAX_W     = WW'(MAX_WIDTH);
    localparam logic [CW-1:0]      DEAD_LOAD = CW'(DEADTIME);

    typedef enum logic [1:0] {IDLE, ARMED, DEAD} state_t;

    state_t                state, state_next;
    logic [TS_WIDTH-1:0]   ts, tag, max_tag, max_tag_next;
    logic signed [DW-1:0]  x, max_val, max_next;
    logic signed [DW:0]    x_ext;
    logic [WW-1:0]         width, width_next;
    logic [CW-1:0]         dead_cnt, dead_next;
    logic                  above, below, emit, emit_pile, runt;

    assign x_ext = {x[DW-1], x};
    assign above = (x_ext > THR_EXT);
    assign below = (x_ext < LOW_EXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        max_next     = max_val;
        max_tag_next = max_tag;
        width_next   = width;
        dead_next    = dead_cnt;
        emit         = 1'b0;
        emit_pile    = 1'b0;
        runt         = 1'b0;
        case (state)
            IDLE: begin
                if (above) begin
                    state_next   = ARMED;
                    max_next     = x;
                    max_tag_next = tag;
                    width_next   = WW'(1);
                end
            end
            ARMED: begin
                // Strict compare: equal samples keep the earliest tag.
                if (x > max_val) begin
                    max_next     = x;
                    max_tag_next = tag;
                end
                if (below) begin
                    if (width >= MIN_W) begin
                        emit       = 1'b1;
                        state_next = DEAD;
                        dead_next  = DEAD_LOAD;
                    end else begin
                        runt       = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    width_next = width + WW'(1);
                    if (width_next == MAX_W) begin
                        emit       = 1'b1;
                        emit_pile  = 1'b1;
                        state_next = DEAD;
                        dead_next  = DEAD_LOAD;
                    end
                end
            end
            DEAD: begin
                if (dead_cnt != '0)  dead_next  = dead_cnt - CW'(1);
                else if (!above)     state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts             <= '0;
            x              <= '0;
            tag            <= '0;
            max_val        <= '0;
            max_tag        <= '0;
            width          <= '0;
            dead_cnt       <= '0;
            busy           <= 1'b0;
            peak_valid     <= 1'b0;
            peak_amplitude <= '0;
            peak_time      <= '0;
            pile_up        <= 1'b0;
            event_count    <= '0;
            runt_count     <= '0;
        end else begin
            ts         <= ts + TS_WIDTH'(1);
            x          <= filter_data;
            tag        <= ts;
            max_val    <= max_next;
            max_tag    <= max_tag_next;
            width      <= width_next;
            dead_cnt   <= dead_next;
            busy       <= (state_next != IDLE);
            peak_valid <= emit;
            if (emit) begin
                peak_amplitude <= max_next;
                peak_time      <= max_tag_next;
                pile_up        <= emit_pile;
                if (event_count != 16'hFFFF) event_count <= event_count + 16'd1;
            end
            if (runt && runt_count != 16'hFFFF) runt_count <= runt_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_v6_peak_detector.sv
// Directed bench for v6_peak_detector: hand-computed pulse records, runts,
// hysteresis, pile-up, dead time and asynchronous reset.
module tb_v6_peak_detector;
    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] filter_data;
    logic signed [15:0] peak_amplitude;
    logic [31:0]        peak_time;
    logic               peak_valid;
    logic               pile_up;
    logic               busy;
    logic [15:0]        event_count;
    logic [15:0]        runt_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int valid_cyc = -1;

    always #5 clk = ~clk;

    v6_peak_detector #(
        .SIZE_FILTER_DATA(15), .THRESHOLD(100), .HYST(10), .MIN_WIDTH(3),
        .MAX_WIDTH(64), .DEADTIME(8), .TS_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .filter_data(filter_data),
        .peak_amplitude(peak_amplitude), .peak_time(peak_time),
        .peak_valid(peak_valid), .pile_up(pile_up), .busy(busy),
        .event_count(event_count), .runt_count(runt_count)
    );

    // After driving sample c, cyc holds c+1: the cycle now observed.
    task automatic drive(input int v);
        filter_data = 16'(v);
        @(posedge clk);
        #1;
        cyc++;
        if (peak_valid === 1'b1) begin
            nvalid++;
            valid_cyc = cyc;
        end
    endtask

    task automatic drive_n(input int v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic do_reset();
        filter_data = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        nvalid = 0;
        valid_cyc = -1;
    endtask

    task automatic test_reset();
        filter_data = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({peak_valid, pile_up, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {peak_valid, pile_up, busy});
        end
        checks++;
        if ({event_count, runt_count} !== 32'd0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d want 0/0", event_count, runt_count);
        end
        do_reset();
        drive_n(0, 5);
        checks++;
        if (peak_amplitude !== 16'sd0 || peak_time !== 32'd0 || busy !== 1'b0 || nvalid != 0) begin
            errors++; $display("FAIL reset_idle: amp=%0d time=%0d busy=%b nvalid=%0d want all 0",
                               peak_amplitude, peak_time, busy, nvalid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_n(0, 11);
        drive(150); drive(300); drive(450); drive(300); drive(150); drive(80); drive(0);
        checks++;
        if (peak_valid !== 1'b1 || cyc != 18) begin
            errors++; $display("FAIL basic_valid_at_18: got valid=%b cyc=%0d want 1 at 18", peak_valid, cyc);
        end
        drive(0);
        checks++;
        if (peak_valid !== 1'b0) begin
            errors++; $display("FAIL basic_single_strobe: got %b want 0", peak_valid);
        end
        checks++;
        if (peak_amplitude !== 16'sd450) begin
            errors++; $display("FAIL basic_amp: got %0d want 450", peak_amplitude);
        end
        checks++;
        if (peak_time !== 32'd13) begin
            errors++; $display("FAIL basic_time: got %0d want 13", peak_time);
        end
        checks++;
        if (pile_up !== 1'b0 || event_count !== 16'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_flags: pile=%b events=%0d busy=%b want 0 1 1",
                               pile_up, event_count, busy);
        end
        drive_n(0, 12);
        checks++;
        if (nvalid != 1 || valid_cyc != 18 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after: nvalid=%0d at %0d busy=%b want 1 at 18 busy 0",
                               nvalid, valid_cyc, busy);
        end
    endtask

    task automatic test_runt();
        do_reset();
        drive(0); drive(150); drive(200); drive(50);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL runt_busy_armed: got %b want 1", busy);
        end
        drive(0);
        checks++;
        if (busy !== 1'b0 || runt_count !== 16'd1) begin
            errors++; $display("FAIL runt_drop: busy=%b runts=%0d want 0 1", busy, runt_count);
        end
        drive_n(0, 6);
        checks++;
        if (nvalid != 0 || event_count !== 16'd0) begin
            errors++; $display("FAIL runt_no_record: nvalid=%0d events=%0d want 0 0", nvalid, event_count);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        drive(0); drive(300); drive(500); drive(500); drive(95); drive(105); drive(95);
        drive(89);
        checks++;
        if (nvalid != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL hyst_no_early_end: nvalid=%0d busy=%b want 0 1", nvalid, busy);
        end
        drive(0); drive(0);
        checks++;
        if (nvalid != 1 || valid_cyc != 9) begin
            errors++; $display("FAIL hyst_end_at_89: nvalid=%0d at %0d want 1 at 9", nvalid, valid_cyc);
        end
        checks++;
        if (peak_amplitude !== 16'sd500 || peak_time !== 32'd2) begin
            errors++; $display("FAIL hyst_tie: amp=%0d time=%0d want 500 2", peak_amplitude, peak_time);
        end
        drive_n(0, 10);
    endtask

    task automatic test_pile_up();
        do_reset();
        drive(0);
        drive_n(200, 64);
        checks++;
        if (nvalid != 0) begin
            errors++; $display("FAIL pile_early: nvalid=%0d want 0", nvalid);
        end
        drive(200);
        checks++;
        if (peak_valid !== 1'b1 || cyc != 66) begin
            errors++; $display("FAIL pile_valid: valid=%b cyc=%0d want 1 at 66", peak_valid, cyc);
        end
        checks++;
        if (peak_amplitude !== 16'sd200 || pile_up !== 1'b1 || peak_time !== 32'd1) begin
            errors++; $display("FAIL pile_record: amp=%0d pile=%b time=%0d want 200 1 1",
                               peak_amplitude, pile_up, peak_time);
        end
        drive_n(200, 15);
        drive(0);
        checks++;
        if (busy !== 1'b1 || nvalid != 1) begin
            errors++; $display("FAIL pile_dead_hold: busy=%b nvalid=%0d want 1 1", busy, nvalid);
        end
        drive(0);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL pile_rearm: busy=%b want 0", busy);
        end
        drive_n(0, 5);
        checks++;
        if (nvalid != 1 || event_count !== 16'd1) begin
            errors++; $display("FAIL pile_single: nvalid=%0d events=%0d want 1 1", nvalid, event_count);
        end
    endtask

    task automatic test_negative_deadtime();
        do_reset();
        drive(0); drive(-500); drive_n(0, 3);
        checks++;
        if (busy !== 1'b0 || nvalid != 0) begin
            errors++; $display("FAIL neg_no_trigger: busy=%b nvalid=%0d want 0 0", busy, nvalid);
        end
        drive(200); drive(300); drive(200); drive(0);
        drive_n(0, 4);
        checks++;
        if (nvalid != 1 || valid_cyc != 10) begin
            errors++; $display("FAIL dead_first: nvalid=%0d at %0d want 1 at 10", nvalid, valid_cyc);
        end
        drive_n(400, 3);
        drive_n(0, 6);
        checks++;
        if (nvalid != 1 || event_count !== 16'd1 || runt_count !== 16'd0 || peak_amplitude !== 16'sd300) begin
            errors++; $display("FAIL dead_ignore: nvalid=%0d events=%0d runts=%0d amp=%0d want 1 1 0 300",
                               nvalid, event_count, runt_count, peak_amplitude);
        end
        drive_n(400, 3);
        drive_n(0, 3);
        checks++;
        if (nvalid != 2 || valid_cyc != 27) begin
            errors++; $display("FAIL dead_accept: nvalid=%0d at %0d want 2 at 27", nvalid, valid_cyc);
        end
        checks++;
        if (peak_amplitude !== 16'sd400 || peak_time !== 32'd22 || event_count !== 16'd2) begin
            errors++; $display("FAIL dead_accept_record: amp=%0d time=%0d events=%0d want 400 22 2",
                               peak_amplitude, peak_time, event_count);
        end
        drive_n(0, 10);
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        drive(0); drive_n(200, 3); drive(0);
        drive_n(0, 11);
        drive(150); drive(300); drive(200);
        checks++;
        if (busy !== 1'b1 || event_count !== 16'd1 || peak_amplitude !== 16'sd200) begin
            errors++; $display("FAIL mid_pre: busy=%b events=%0d amp=%0d want 1 1 200",
                               busy, event_count, peak_amplitude);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({peak_valid, pile_up, busy} !== 3'b000 || event_count !== 16'd0 || runt_count !== 16'd0) begin
            errors++; $display("FAIL mid_async_flags: flags=%b events=%0d runts=%0d want 000 0 0",
                               {peak_valid, pile_up, busy}, event_count, runt_count);
        end
        checks++;
        if (peak_amplitude !== 16'sd0 || peak_time !== 32'd0) begin
            errors++; $display("FAIL mid_async_record: amp=%0d time=%0d want 0 0", peak_amplitude, peak_time);
        end
        do_reset();
        drive_n(0, 10);
        checks++;
        if (nvalid != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_discard: nvalid=%0d busy=%b want 0 0", nvalid, busy);
        end
        drive(250); drive(400); drive(250); drive(0); drive_n(0, 3);
        checks++;
        if (nvalid != 1 || valid_cyc != 15 || peak_time !== 32'd11 || peak_amplitude !== 16'sd400) begin
            errors++; $display("FAIL mid_ts_restart: nvalid=%0d at %0d time=%0d amp=%0d want 1 at 15 11 400",
                               nvalid, valid_cyc, peak_time, peak_amplitude);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_runt();
        test_hysteresis();
        test_pile_up();
        test_negative_deadtime();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
